instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Reader side of the instruction ROM interface. Owns the program counter, drives the
//  ROM address, captures the returned opcode byte and immediate byte, and sizes each
//  instruction as 1 or 2 words so the PC steps over immediates. Sits between
//  instruction memory and decode; it also accepts stall and jump requests from the core.
// PARAMETERS
//  RESET_PC    0             PC value loaded on reset
//  ADDR_W      word_length   PC / ROM address width (8)
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  mem_addr     out  ADDR_W  ROM address (= pc_q, combinational from register)
//  mem_instr    in   8       ROM data at mem_addr (same cycle, combinational ROM)
//  mem_imm      in   8       ROM data at mem_addr+1 (same cycle)
//  stall        in   1       hold: no PC advance, outputs frozen
//  jmp_en       in   1       redirect PC to jmp_addr
//  jmp_addr     in   ADDR_W  jump target
//  instr        out  8       registered instruction {opcode[7:4], ra[3:2], rb[1:0]}
//  imm          out  8       registered immediate, 0 when instruction has none
//  instr_pc     out  ADDR_W  address instr was fetched from
//  instr_valid  out  1       instr/imm/instr_pc hold a real instruction this cycle
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc_q<=RESET_PC, state<=BUBBLE, instr<=0 (NOP,RegA,RegA),
//    imm<=0, instr_pc<=0, instr_valid<=0. rst overrides every other input.
//  - States: BUBBLE (no valid output this cycle), RUN. BUBBLE->RUN after one cycle
//    unless stall=1. Entered from reset and after every taken jump.
//  - Latency: mem_addr=pc_q in cycle N; instr/imm/instr_pc/instr_valid show it in N+1.
//  - Size: len = has_imm(mem_instr[7:4]) ? 2 : 1. On fetch: instr<=mem_instr,
//    imm<= (len==2) ? mem_imm : 0, instr_pc<=pc_q, instr_valid<=1, pc_q<=pc_q+len.
//  - Arithmetic: pc_q+len is ADDR_W-bit, wraps modulo 2**ADDR_W; 2-word instruction at
//    address 0xFF takes its immediate from 0x00 (ROM returns addr+1 wrapped). No trap.
//  - stall=1 (no jmp_en): pc_q, instr, imm, instr_pc, instr_valid all hold; state holds.
//  - jmp_en=1: pc_q<=jmp_addr, state<=BUBBLE, instr_valid<=0 next cycle; instruction
//    at old pc_q is discarded. jmp_en has priority over stall. jmp_en during BUBBLE
//    is also taken (latest target wins).
//  - Simultaneous rst and jmp_en: reset wins. Reset mid-instruction: no partial
//    state survives; first valid output is at RESET_PC two cycles after rst falls.
//  - In BUBBLE with stall=0: a fetch is performed as in RUN except instr_valid stays 0
//    and pc_q does NOT advance (the bubble only lets mem_addr settle after redirect).
// STRUCTURE
//  - project_pkg: word, word_length, rom_length, opcode enum (NOP, ADDI, WO, ...),
//    function has_imm(opcode) returning 1 for immediate-form opcodes (ADDI, ...),
//    fetch_state_t enum {BUBBLE, RUN}.
//  - No sub-module; one always_ff for pc/state/outputs, one always_comb for next-pc.
//  - mem_addr feeds instr_mem addr; mem_instr/mem_imm take instr_mem instr/imm.
// TESTING
//  1 ROM {NOP,RegA,RegA},{ADDI,RegA,RegA},8'hFF,{WO,RegA,RegA}; release rst ->
//    cycle1 invalid; then NOP@0 imm 0, ADDI@1 imm FF, WO@3 imm 0, mem_addr 0,1,3,4.
//  2 stall=1 for 3 cycles while ADDI@1 is shown -> outputs and mem_addr frozen 3 cycles,
//    then WO@3 next.
//  3 jmp_en=1, jmp_addr=0 while showing WO@3 -> next cycle instr_valid=0, then NOP@0.
//  4 jmp_en=1 and stall=1 same cycle, target 1 -> jump taken, bubble, ADDI@1 imm FF.
//  5 ADDI at 0xFF, ROM[0x00]=8'h5A -> imm=5A, instr_pc=FF, next mem_addr=0x01.
//  6 assert rst for 1 cycle mid-stream and with jmp_en=1 -> all outputs 0, pc=RESET_PC,
//    first valid instruction from RESET_PC two cycles later.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch path: word type, opcode set,
// register names, fetch FSM states and the instruction-size helper.
package instr_fetch_pkg;

  localparam int word_length = 8;
  localparam int rom_length  = 256;

  typedef logic [word_length-1:0] word;

  typedef enum logic [3:0] {
    NOP  = 4'h0,
    ADD  = 4'h1,
    SUB  = 4'h2,
    ADDI = 4'h3,
    LI   = 4'h4,
    LD   = 4'h5,
    ST   = 4'h6,
    WO   = 4'h7,
    RI   = 4'h8,
    AND  = 4'h9,
    OR   = 4'hA,
    XOR  = 4'hB,
    SHL  = 4'hC,
    JMP  = 4'hD,
    JZ   = 4'hE,
    HLT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    RegA = 2'd0,
    RegB = 2'd1,
    RegC = 2'd2,
    RegD = 2'd3
  } reg_t;

  typedef enum logic {
    BUBBLE = 1'b0,
    RUN    = 1'b1
  } fetch_state_t;

  // Immediate-form opcodes occupy two ROM words: opcode byte then immediate byte.
  function automatic logic has_imm(input opcode_t op);
    case (op)
      ADDI, LI, LD, ST, JMP, JZ: has_imm = 1'b1;
      default:                   has_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, addresses the combinational ROM, registers
// the fetched opcode/immediate for decode and steps over immediates.
// A one-cycle bubble follows reset and every taken jump.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W   = word_length,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_instr,
  input  logic [7:0]        mem_imm,
  input  logic              stall,
  input  logic              jmp_en,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [7:0]        instr,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next_p0;
  logic              two_word_p0;
  logic [7:0]        imm_sel_p0;

  logic [7:0]        instr_p1;
  logic [7:0]        imm_p1;
  logic [ADDR_W-1:0] instr_pc_p1;
  logic              vld_p1;

  assign mem_addr = pc_q;

  // Size the instruction at pc_q and form the sequential next PC (wraps modulo 2**ADDR_W).
  always_comb begin
    two_word_p0 = has_imm(opcode_t'(mem_instr[7:4]));
    imm_sel_p0  = two_word_p0 ? mem_imm : 8'h00;
    pc_next_p0  = two_word_p0 ? pc_q + ADDR_W'(2) : pc_q + ADDR_W'(1);
  end

  // ---- stage p0 -> p1: PC / FSM update and registered fetch outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= ADDR_W'(RESET_PC);
      state       <= BUBBLE;
      instr_p1    <= 8'h00;
      imm_p1      <= 8'h00;
      instr_pc_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (jmp_en) begin
      pc_q   <= jmp_addr;
      state  <= BUBBLE;
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      instr_p1    <= mem_instr;
      imm_p1      <= imm_sel_p0;
      instr_pc_p1 <= pc_q;
      if (state == BUBBLE) begin
        vld_p1 <= 1'b0;
        state  <= RUN;
      end else begin
        vld_p1 <= 1'b1;
        pc_q   <= pc_next_p0;
      end
    end
  end

  assign instr       = instr_p1;
  assign imm         = imm_p1;
  assign instr_pc    = instr_pc_p1;
  assign instr_valid = vld_p1;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a combinational ROM model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr;
  logic [7:0] mem_instr;
  logic [7:0] mem_imm;
  logic       stall;
  logic       jmp_en;
  logic [7:0] jmp_addr;
  logic [7:0] instr;
  logic [7:0] imm;
  logic [7:0] instr_pc;
  logic       instr_valid;

  logic [7:0] rom [rom_length];
  logic [7:0] addr_plus1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign addr_plus1 = mem_addr + 8'd1;
  assign mem_instr  = rom[mem_addr];
  assign mem_imm    = rom[addr_plus1];

  instr_fetch #(.ADDR_W(8), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_instr   (mem_instr),
    .mem_imm     (mem_imm),
    .stall       (stall),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .instr       (instr),
    .imm         (imm),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_valid(input string tag, input logic [7:0] ei, input logic [7:0] em,
                           input logic [7:0] ep, input logic [7:0] ea);
    chk({tag, ".valid"},    32'(instr_valid), 32'd1);
    chk({tag, ".instr"},    32'(instr),       32'(ei));
    chk({tag, ".imm"},      32'(imm),         32'(em));
    chk({tag, ".instr_pc"}, 32'(instr_pc),    32'(ep));
    chk({tag, ".mem_addr"}, 32'(mem_addr),    32'(ea));
  endtask

  task automatic chk_bubble(input string tag, input logic [7:0] ea);
    chk({tag, ".valid"},    32'(instr_valid), 32'd0);
    chk({tag, ".mem_addr"}, 32'(mem_addr),    32'(ea));
  endtask

  initial begin
    for (int i = 0; i < rom_length; i++) rom[i] = 8'h00;
    rom[0] = 8'h00;  // NOP RegA,RegA
    rom[1] = 8'h30;  // ADDI RegA,RegA
    rom[2] = 8'hFF;  // immediate
    rom[3] = 8'h70;  // WO RegA,RegA
    rom[4] = 8'h00;

    rst = 1'b1; stall = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00;
    step();
    step();
    chk("rst.instr",    32'(instr),       32'h0);
    chk("rst.imm",      32'(imm),         32'h0);
    chk("rst.instr_pc", 32'(instr_pc),    32'h0);
    chk("rst.valid",    32'(instr_valid), 32'h0);
    chk("rst.mem_addr", 32'(mem_addr),    32'h0);

    // Sequential fetch after reset release
    rst = 1'b0;
    step(); chk_bubble("t1.bubble", 8'h00);
    step(); chk_valid("t1.nop0",  8'h00, 8'h00, 8'h00, 8'h01);
    step(); chk_valid("t1.addi1", 8'h30, 8'hFF, 8'h01, 8'h03);

    // Stall holds everything for three cycles
    stall = 1'b1;
    step(); chk_valid("t2.hold1", 8'h30, 8'hFF, 8'h01, 8'h03);
    step(); chk_valid("t2.hold2", 8'h30, 8'hFF, 8'h01, 8'h03);
    step(); chk_valid("t2.hold3", 8'h30, 8'hFF, 8'h01, 8'h03);
    stall = 1'b0;
    step(); chk_valid("t2.wo3",   8'h70, 8'h00, 8'h03, 8'h04);

    // Jump back to 0 while WO@3 is shown
    jmp_en = 1'b1; jmp_addr = 8'h00;
    step(); chk_bubble("t3.jmp", 8'h00);
    jmp_en = 1'b0;
    step(); chk_bubble("t3.bubble", 8'h00);
    step(); chk_valid("t3.nop0", 8'h00, 8'h00, 8'h00, 8'h01);

    // Jump has priority over stall
    jmp_en = 1'b1; stall = 1'b1; jmp_addr = 8'h01;
    step(); chk_bubble("t4.jmp", 8'h01);
    jmp_en = 1'b0; stall = 1'b0;
    step(); chk_bubble("t4.bubble", 8'h01);
    step(); chk_valid("t4.addi1", 8'h30, 8'hFF, 8'h01, 8'h03);

    // Two-word instruction at 0xFF takes its immediate from 0x00
    rom[8'hFF] = 8'h30;
    rom[0]     = 8'h5A;
    jmp_en = 1'b1; jmp_addr = 8'hFF;
    step(); chk_bubble("t5.jmp", 8'hFF);
    jmp_en = 1'b0;
    step(); chk_bubble("t5.bubble", 8'hFF);
    step(); chk_valid("t5.addiFF", 8'h30, 8'h5A, 8'hFF, 8'h01);
    rom[0] = 8'h00;
    step(); chk_valid("t6.addi1", 8'h30, 8'hFF, 8'h01, 8'h03);

    // Reset mid-stream together with a jump request: reset wins
    rst = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h80;
    step();
    chk("t6.rst.instr",    32'(instr),       32'h0);
    chk("t6.rst.imm",      32'(imm),         32'h0);
    chk("t6.rst.instr_pc", 32'(instr_pc),    32'h0);
    chk("t6.rst.valid",    32'(instr_valid), 32'h0);
    chk("t6.rst.mem_addr", 32'(mem_addr),    32'h0);
    rst = 1'b0; jmp_en = 1'b0;
    step(); chk_bubble("t6.bubble", 8'h00);
    step(); chk_valid("t6.nop0", 8'h00, 8'h00, 8'h00, 8'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
